// File: rtl/ldpc_sched_pkg.sv
// Shared types and defaults for the layered LDPC iteration scheduler.
package ldpc_sched_pkg;

  localparam int unsigned NUM_LAYERS_DEF = 8;
  localparam int unsigned ITER_W_DEF     = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_LAYER = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CHECK = 3'd4,
    ST_OUT   = 3'd5
  } sched_state_t;

  typedef struct packed {
    logic [ITER_W_DEF-1:0] iters;
    logic                  pass;
  } sched_result_t;

endpackage

// File: rtl/ldpc_dec_sched.sv
// Iteration scheduler for the layered LDPC decoder core: LLR load, per-layer
// sequencing, syndrome check and result handshake.
// Optional build macro LDPC_EARLY_TERM_EN: stop as soon as the syndrome is zero.
module ldpc_dec_sched
  import ldpc_sched_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int unsigned ITER_W     = ITER_W_DEF,
  parameter int unsigned LAYER_W    = $clog2(NUM_LAYERS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cb_valid,
  output logic               cb_ready,
  input  logic [ITER_W-1:0]  cb_max_iter,
  output logic               load_start,
  input  logic               load_done,
  output logic               layer_start,
  output logic [LAYER_W-1:0] layer_idx,
  input  logic               layer_done,
  input  logic               syn_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ITER_W-1:0]  out_iters,
  output logic               out_pass,
  output logic               busy
);

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [ITER_W-1:0]  ONE_ITER   = ITER_W'(1);

`ifdef LDPC_EARLY_TERM_EN
  localparam logic EARLY_TERM = 1'b1;
`else
  localparam logic EARLY_TERM = 1'b0;
`endif

  sched_state_t      state;
  logic [ITER_W-1:0] max_iter;
  logic [ITER_W-1:0] iter_cnt;
  logic              terminate_c;

  // Termination decision evaluated while in CHECK.
  assign terminate_c = (EARLY_TERM && syn_zero) || (iter_cnt == max_iter);

  // Scheduler FSM with registered outputs and the layer/iteration counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cb_ready    <= 1'b0;
      load_start  <= 1'b0;
      layer_start <= 1'b0;
      layer_idx   <= '0;
      out_valid   <= 1'b0;
      out_iters   <= '0;
      out_pass    <= 1'b0;
      busy        <= 1'b0;
      max_iter    <= ONE_ITER;
      iter_cnt    <= '0;
    end else begin
      load_start  <= 1'b0;
      layer_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          cb_ready <= 1'b1;
          if (cb_ready && cb_valid) begin
            max_iter   <= (cb_max_iter == '0) ? ONE_ITER : cb_max_iter;
            iter_cnt   <= '0;
            cb_ready   <= 1'b0;
            busy       <= 1'b1;
            load_start <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_done) begin
            layer_idx   <= '0;
            layer_start <= 1'b1;
            state       <= ST_LAYER;
          end
        end
        ST_LAYER: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (layer_done) begin
            if (layer_idx < LAST_LAYER) begin
              layer_idx   <= layer_idx + LAYER_W'(1);
              layer_start <= 1'b1;
              state       <= ST_LAYER;
            end else begin
              layer_idx <= '0;
              iter_cnt  <= iter_cnt + ONE_ITER;
              state     <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (terminate_c) begin
            out_iters <= iter_cnt;
            out_pass  <= syn_zero;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            layer_start <= 1'b1;
            state       <= ST_LAYER;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cb_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_dec_sched.sv
// Scoreboard bench for ldpc_dec_sched: a core responder answers load/layer
// pulses, a monitor checks layer indices and every result handshake.
module tb_ldpc_dec_sched;
  import ldpc_sched_pkg::*;

  localparam int NL = int'(NUM_LAYERS_DEF);
  localparam int unsigned IW = ITER_W_DEF;
  localparam int unsigned LW = $clog2(NUM_LAYERS_DEF);

  logic          clk;
  logic          rst;
  logic          cb_valid;
  logic          cb_ready;
  logic [IW-1:0] cb_max_iter;
  logic          load_start;
  wire logic     load_done;
  logic          layer_start;
  logic [LW-1:0] layer_idx;
  wire logic     layer_done;
  logic          syn_zero;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_iters;
  logic          out_pass;
  logic          busy;

  logic resp_load_done, resp_layer_done;
  logic inj_load_done, inj_layer_done;
  assign load_done  = resp_load_done | inj_load_done;
  assign layer_done = resp_layer_done | inj_layer_done;

  typedef struct {
    sched_result_t res;
    int            layers;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   syn_at = 0;
  int   load_delay = 0;
  int   layer_delay = 0;

  ldpc_dec_sched dut (
    .clk(clk), .rst(rst), .cb_valid(cb_valid), .cb_ready(cb_ready),
    .cb_max_iter(cb_max_iter), .load_start(load_start), .load_done(load_done),
    .layer_start(layer_start), .layer_idx(layer_idx), .layer_done(layer_done),
    .syn_zero(syn_zero), .out_valid(out_valid), .out_ready(out_ready),
    .out_iters(out_iters), .out_pass(out_pass), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decoder core model: answers pulses after a programmable delay, raises
  // syn_zero once syn_at iterations have been completed.
  initial begin
    int ld_cnt, ly_cnt, layers_done;
    ld_cnt = 0; ly_cnt = 0; layers_done = 0;
    resp_load_done = 1'b0; resp_layer_done = 1'b0; syn_zero = 1'b0;
    forever begin
      @(negedge clk);
      resp_load_done  = 1'b0;
      resp_layer_done = 1'b0;
      if (rst) begin
        ld_cnt = 0; ly_cnt = 0; layers_done = 0; syn_zero = 1'b0;
      end else begin
        if (ld_cnt > 0) begin
          ld_cnt--;
          if (ld_cnt == 0) resp_load_done = 1'b1;
        end
        if (ly_cnt > 0) begin
          ly_cnt--;
          if (ly_cnt == 0) begin
            resp_layer_done = 1'b1;
            layers_done++;
            syn_zero = (syn_at != 0) && ((layers_done / NL) >= syn_at);
          end
        end
        if (load_start) begin
          ld_cnt = load_delay + 1;
          layers_done = 0;
          syn_zero = 1'b0;
        end
        if (layer_start) ly_cnt = layer_delay + 1;
      end
    end
  end

  // Monitor: layer index sequence and result checking against the scoreboard.
  initial begin
    int mon_layers, mon_loads;
    exp_t e;
    mon_layers = 0; mon_loads = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_layers = 0; mon_loads = 0;
      end else begin
        if (load_start) begin
          mon_loads++;
          mon_layers = 0;
        end
        if (layer_start) begin
          check("layer_idx_seq", int'(layer_idx), mon_layers % NL);
          mon_layers++;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = sb.pop_front();
            check("out_iters", int'(out_iters), int'(e.res.iters));
            check("out_pass", int'(out_pass), int'(e.res.pass));
            check("layer_pulses", mon_layers, e.layers);
            check("load_pulses", mon_loads, 1);
          end
          mon_loads = 0;
        end
      end
    end
  end

  task automatic launch(input int mi, input int sa);
    syn_at = sa;
    for (int i = 0; i < 50 && !cb_ready; i++) tick();
    check("cb_ready_before_job", int'(cb_ready), 1);
    cb_valid = 1'b1;
    cb_max_iter = IW'(mi);
    tick();
    cb_valid = 1'b0;
    check("load_start_pulse", int'(load_start), 1);
    check("busy_after_accept", int'(busy), 1);
    check("cb_ready_after_accept", int'(cb_ready), 0);
  endtask

  task automatic start_job(input int mi, input int sa, input int e_iters, input int e_pass);
    exp_t e;
    e.res.iters = IW'(e_iters);
    e.res.pass  = (e_pass != 0);
    e.layers    = e_iters * NL;
    sb.push_back(e);
    launch(mi, sa);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && (busy || out_valid); i++) tick();
    check("job_completion", int'(busy), 0);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; cb_valid = 1'b0; cb_max_iter = '0; out_ready = 1'b1;
    inj_load_done = 1'b0; inj_layer_done = 1'b0;
    tick(); tick();
    check("rst_cb_ready", int'(cb_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_layer_idx", int'(layer_idx), 0);
    check("rst_load_start", int'(load_start), 0);
    check("rst_layer_start", int'(layer_start), 0);
    check("rst_out_iters", int'(out_iters), 0);
    check("rst_out_pass", int'(out_pass), 0);
    rst = 1'b0;
    tick();
    check("cb_ready_after_rst", int'(cb_ready), 1);

    // Three full iterations, syndrome never clears.
    start_job(3, 0, 3, 0);
    wait_done();

    // Syndrome clears after iteration 2 of a 10-iteration budget.
`ifdef LDPC_EARLY_TERM_EN
    start_job(10, 2, 2, 1);
`else
    start_job(10, 2, 10, 1);
`endif
    wait_done();

    // Zero iteration limit runs one iteration.
    start_job(0, 0, 1, 0);
    wait_done();

    // Output back-pressure for 5 cycles.
    out_ready = 1'b0;
    start_job(1, 1, 1, 1);
    for (int i = 0; i < 3000 && !out_valid; i++) tick();
    check("stall_out_valid_rise", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_iters", int'(out_iters), 1);
      check("stall_out_pass", int'(out_pass), 1);
      check("stall_cb_ready", int'(cb_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("post_hs_out_valid", int'(out_valid), 0);
    check("post_hs_cb_ready", int'(cb_ready), 1);
    check("post_hs_busy", int'(busy), 0);
    wait_done();

    // Spurious completions in IDLE, LOAD and WAIT.
    inj_layer_done = 1'b1; inj_load_done = 1'b1;
    tick();
    inj_layer_done = 1'b0; inj_load_done = 1'b0;
    check("idle_spur_busy", int'(busy), 0);
    check("idle_spur_cb_ready", int'(cb_ready), 1);
    check("idle_spur_load_start", int'(load_start), 0);
    check("idle_spur_layer_start", int'(layer_start), 0);
    load_delay = 4; layer_delay = 3;
    start_job(1, 0, 1, 0);
    inj_layer_done = 1'b1;
    tick();
    inj_layer_done = 1'b0;
    check("load_spur_load_start", int'(load_start), 0);
    check("load_spur_layer_start", int'(layer_start), 0);
    check("load_spur_busy", int'(busy), 1);
    for (int i = 0; i < 100 && !layer_start; i++) tick();
    check("first_layer_start", int'(layer_start), 1);
    tick();
    inj_load_done = 1'b1;
    tick();
    inj_load_done = 1'b0;
    check("wait_spur_layer_start", int'(layer_start), 0);
    check("wait_spur_load_start", int'(load_start), 0);
    wait_done();

    // Reset while waiting in iteration 2, then a clean job.
    layer_delay = 3; load_delay = 0;
    launch(5, 0);
    seen = 0;
    for (int i = 0; i < 500 && seen < NL + 1; i++) begin
      if (layer_start) seen++;
      if (seen < NL + 1) tick();
    end
    check("iter2_reached", seen, NL + 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_layer_idx", int'(layer_idx), 0);
    check("abort_cb_ready", int'(cb_ready), 0);
    check("abort_layer_start", int'(layer_start), 0);
    tick();
    check("abort_cb_ready_next", int'(cb_ready), 1);
    layer_delay = 0;
    start_job(2, 0, 2, 0);
    wait_done();

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
